// File: rtl/uart_pkg.sv
// uart_pkg
//   Shared types and helpers for the UART transmit path.
//   tx_state_e  : serialiser states
//   parity_e    : parity selection (cfg_parity_type encoding)
//   data_bits_e : data width selection (cfg_data_bits encoding)
//   num_data_bits / data_mask / parity_bit : frame-format helpers
package uart_pkg;

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_PARITY,
        TX_STOP,
        TX_BREAK,
        TX_MARK
    } tx_state_e;

    typedef enum logic [1:0] {
        PAR_EVEN  = 2'b00,
        PAR_ODD   = 2'b01,
        PAR_MARK  = 2'b10,
        PAR_SPACE = 2'b11
    } parity_e;

    typedef enum logic [1:0] {
        DB_5 = 2'b00,
        DB_6 = 2'b01,
        DB_7 = 2'b10,
        DB_8 = 2'b11
    } data_bits_e;

    function automatic logic [3:0] num_data_bits(input data_bits_e db);
        return 4'd5 + {2'b00, db};
    endfunction

    function automatic logic [7:0] data_mask(input data_bits_e db);
        return 8'hFF >> (4'd8 - num_data_bits(db));
    endfunction

    // Expects data already masked to the active bits.
    function automatic logic parity_bit(input parity_e p, input logic [7:0] d);
        case (p)
            PAR_EVEN: return ^d;
            PAR_ODD:  return ~^d;
            PAR_MARK: return 1'b1;
            default:  return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/bit_sync.sv
// bit_sync
//   Multi-flop synchroniser for a single asynchronous level.
//   clk    : destination clock
//   rst_n  : synchronous active-low reset (flops load RST_VAL)
//   i_d    : asynchronous input
//   o_q    : synchronised output (STAGES cycles of latency, STAGES >= 2)
module bit_sync #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_d,
    output logic o_q
);

    logic [STAGES-1:0] r_sync;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sync <= {STAGES{RST_VAL}};
        end else begin
            r_sync <= {r_sync[STAGES-2:0], i_d};
        end
    end

    assign o_q = r_sync[STAGES-1];

endmodule

// File: rtl/sync_fifo.sv
// sync_fifo
//   Single-clock FIFO with occupancy count, flush and overflow pulse.
//   clk, rst_n  : clock, synchronous active-low reset
//   i_flush     : clears contents (a write in the same cycle is discarded)
//   i_wr_en/i_wr_data : enqueue; ignored while full
//   i_rd_en     : dequeue; o_rd_data shows the head combinationally
//   o_empty/o_full/o_level : status, level 0..DEPTH
//   o_overflow  : 1-cycle pulse after a write attempt while full
module sync_fifo #(
    parameter  int DEPTH = 16,
    parameter  int WIDTH = 8,
    localparam int AW    = $clog2(DEPTH),
    localparam int LW    = AW + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_flush,
    input  logic             i_wr_en,
    input  logic [WIDTH-1:0] i_wr_data,
    input  logic             i_rd_en,
    output logic [WIDTH-1:0] o_rd_data,
    output logic             o_empty,
    output logic             o_full,
    output logic [LW-1:0]    o_level,
    output logic             o_overflow
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [LW-1:0]    r_count;
    logic             r_overflow;
    logic             w_wr_ok;
    logic             w_rd_ok;

    assign o_empty    = (r_count == '0);
    assign o_full     = (r_count == LW'(DEPTH));
    assign o_level    = r_count;
    assign o_overflow = r_overflow;
    assign o_rd_data  = r_mem[r_rd_ptr];
    assign w_wr_ok    = i_wr_en && !o_full;
    assign w_rd_ok    = i_rd_en && !o_empty;

    always_ff @(posedge clk) begin
        if (w_wr_ok) begin
            r_mem[r_wr_ptr] <= i_wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_rd_ok) r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_wr_ok, w_rd_ok})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // A pop in the same cycle does not make room for a write seen while full.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_overflow <= 1'b0;
        end else begin
            r_overflow <= i_wr_en && o_full;
        end
    end

endmodule

// File: rtl/uart_tx_frame.sv
// uart_tx_frame
//   UART transmit datapath: TX FIFO feeding a frame serialiser with
//   runtime format (5-8 data bits, parity, 1/2 stop), break and CTS.
//   uart_clk, rst_n : clock, synchronous active-low reset
//   baud_tick       : oversample tick, OVERSAMPLE ticks per bit
//   cfg_*           : frame format / break / CTS enable, latched per frame
//   cts_n           : asynchronous clear-to-send, active-low
//   wr_data/wr_en/flush : FIFO write side
//   tx_empty/tx_full/tx_level/wr_overflow : FIFO status
//   tx_active/tx_done/tx_serial : serialiser status and line
//
//   state     | meaning
//   TX_IDLE   | line high, waiting for data or break request
//   TX_START  | start bit (0)
//   TX_DATA   | data bits, LSB first
//   TX_PARITY | parity bit
//   TX_STOP   | stop bit(s) (1)
//   TX_BREAK  | line held low while cfg_break is set
//   TX_MARK   | one bit period of high line after a break
module uart_tx_frame
    import uart_pkg::*;
#(
    parameter  int FIFO_DEPTH = 16,
    parameter  int OVERSAMPLE = 16,
    localparam int LVL_W      = $clog2(FIFO_DEPTH) + 1
) (
    input  logic             uart_clk,
    input  logic             rst_n,
    input  logic             baud_tick,
    input  logic [1:0]       cfg_data_bits,
    input  logic             cfg_parity_en,
    input  logic [1:0]       cfg_parity_type,
    input  logic             cfg_stop2,
    input  logic             cfg_break,
    input  logic             cfg_cts_en,
    input  logic             cts_n,
    input  logic [7:0]       wr_data,
    input  logic             wr_en,
    input  logic             flush,
    output logic             tx_empty,
    output logic             tx_full,
    output logic [LVL_W-1:0] tx_level,
    output logic             tx_active,
    output logic             tx_done,
    output logic             wr_overflow,
    output logic             tx_serial
);

    localparam int            TW        = $clog2(OVERSAMPLE);
    localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);

    tx_state_e     r_state;
    logic [TW-1:0] r_tick;
    logic [7:0]    r_shift;
    logic [3:0]    r_bits_left;
    logic          r_stop_left;
    logic          r_stop2;
    logic          r_par_en;
    logic          r_par_bit;
    logic          r_serial;
    logic          r_done;

    logic          w_cts_n_sync;
    logic [7:0]    w_fifo_rd_data;
    logic          w_fifo_empty;
    logic          w_wrap;
    logic          w_start_ok;
    logic          w_stop_end;
    logic          w_pop;
    logic [7:0]    w_load_data;

    bit_sync #(
        .STAGES  (2),
        .RST_VAL (1'b1)
    ) u_cts_sync (
        .clk   (uart_clk),
        .rst_n (rst_n),
        .i_d   (cts_n),
        .o_q   (w_cts_n_sync)
    );

    sync_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk        (uart_clk),
        .rst_n      (rst_n),
        .i_flush    (flush),
        .i_wr_en    (wr_en),
        .i_wr_data  (wr_data),
        .i_rd_en    (w_pop),
        .o_rd_data  (w_fifo_rd_data),
        .o_empty    (w_fifo_empty),
        .o_full     (tx_full),
        .o_level    (tx_level),
        .o_overflow (wr_overflow)
    );

    assign tx_empty   = w_fifo_empty;
    assign tx_active  = (r_state != TX_IDLE);
    assign tx_done    = r_done;
    assign tx_serial  = r_serial;

    // Tick counter runs down; a bit period ends on the tick that sees zero.
    assign w_wrap      = baud_tick && (r_tick == '0);
    assign w_start_ok  = !w_fifo_empty && !cfg_break && (!cfg_cts_en || !w_cts_n_sync);
    assign w_stop_end  = (r_state == TX_STOP) && w_wrap && !r_stop_left;
    // Launching straight from the last stop wrap keeps back-to-back frames gapless.
    assign w_pop       = baud_tick && w_start_ok && ((r_state == TX_IDLE) || w_stop_end);
    assign w_load_data = w_fifo_rd_data & data_mask(data_bits_e'(cfg_data_bits));

    always_ff @(posedge uart_clk) begin
        if (!rst_n) begin
            r_state     <= TX_IDLE;
            r_tick      <= TICK_LAST;
            r_shift     <= '0;
            r_bits_left <= '0;
            r_stop_left <= 1'b0;
            r_stop2     <= 1'b0;
            r_par_en    <= 1'b0;
            r_par_bit   <= 1'b0;
            r_serial    <= 1'b1;
            r_done      <= 1'b0;
        end else begin
            r_done <= w_stop_end;

            if (r_state == TX_IDLE || r_state == TX_BREAK) begin
                r_tick <= TICK_LAST;
            end else if (baud_tick) begin
                r_tick <= w_wrap ? TICK_LAST : r_tick - 1'b1;
            end

            if (w_pop) begin
                r_state     <= TX_START;
                r_serial    <= 1'b0;
                r_shift     <= w_load_data;
                r_bits_left <= num_data_bits(data_bits_e'(cfg_data_bits));
                r_stop2     <= cfg_stop2;
                r_par_en    <= cfg_parity_en;
                r_par_bit   <= parity_bit(parity_e'(cfg_parity_type), w_load_data);
            end else begin
                case (r_state)
                    TX_IDLE: begin
                        if (baud_tick && cfg_break) begin
                            r_state  <= TX_BREAK;
                            r_serial <= 1'b0;
                        end
                    end
                    TX_START: begin
                        if (w_wrap) begin
                            r_state  <= TX_DATA;
                            r_serial <= r_shift[0];
                        end
                    end
                    TX_DATA: begin
                        if (w_wrap) begin
                            if (r_bits_left == 4'd1) begin
                                if (r_par_en) begin
                                    r_state  <= TX_PARITY;
                                    r_serial <= r_par_bit;
                                end else begin
                                    r_state     <= TX_STOP;
                                    r_serial    <= 1'b1;
                                    r_stop_left <= r_stop2;
                                end
                            end else begin
                                r_shift     <= r_shift >> 1;
                                r_serial    <= r_shift[1];
                                r_bits_left <= r_bits_left - 1'b1;
                            end
                        end
                    end
                    TX_PARITY: begin
                        if (w_wrap) begin
                            r_state     <= TX_STOP;
                            r_serial    <= 1'b1;
                            r_stop_left <= r_stop2;
                        end
                    end
                    TX_STOP: begin
                        if (w_wrap) begin
                            if (r_stop_left) begin
                                r_stop_left <= 1'b0;
                            end else begin
                                r_state <= TX_IDLE;
                            end
                        end
                    end
                    TX_BREAK: begin
                        if (!cfg_break) begin
                            r_state  <= TX_MARK;
                            r_serial <= 1'b1;
                        end
                    end
                    TX_MARK: begin
                        if (w_wrap) begin
                            r_state <= TX_IDLE;
                        end
                    end
                    default: begin
                        r_state  <= TX_IDLE;
                        r_serial <= 1'b1;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_frame.sv
module tb_uart_tx_frame;

    logic       uart_clk = 1'b0;
    logic       rst_n;
    logic       baud_tick;
    logic [1:0] cfg_data_bits;
    logic       cfg_parity_en;
    logic [1:0] cfg_parity_type;
    logic       cfg_stop2;
    logic       cfg_break;
    logic       cfg_cts_en;
    logic       cts_n;
    logic [7:0] wr_data;
    logic       wr_en;
    logic       flush;
    logic       tx_empty;
    logic       tx_full;
    logic [4:0] tx_level;
    logic       tx_active;
    logic       tx_done;
    logic       wr_overflow;
    logic       tx_serial;

    uart_tx_frame #(
        .FIFO_DEPTH (16),
        .OVERSAMPLE (16)
    ) dut (
        .uart_clk        (uart_clk),
        .rst_n           (rst_n),
        .baud_tick       (baud_tick),
        .cfg_data_bits   (cfg_data_bits),
        .cfg_parity_en   (cfg_parity_en),
        .cfg_parity_type (cfg_parity_type),
        .cfg_stop2       (cfg_stop2),
        .cfg_break       (cfg_break),
        .cfg_cts_en      (cfg_cts_en),
        .cts_n           (cts_n),
        .wr_data         (wr_data),
        .wr_en           (wr_en),
        .flush           (flush),
        .tx_empty        (tx_empty),
        .tx_full         (tx_full),
        .tx_level        (tx_level),
        .tx_active       (tx_active),
        .tx_done         (tx_done),
        .wr_overflow     (wr_overflow),
        .tx_serial       (tx_serial)
    );

    always #5 uart_clk = ~uart_clk;

    int checks = 0;
    int errors = 0;

    // Reference model: bytes queued for transmission, FIFO occupancy, current format.
    logic [7:0] exp_q[$];
    int         model_level = 0;
    int         cur_bits;
    int         cur_par_en;
    int         cur_ptype;
    int         cur_stop2;

    logic line_s [0:3199];
    logic done_s [0:3199];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_cfg(input int nbits, input int pen, input int pt, input int s2);
        cfg_data_bits   = 2'(nbits - 5);
        cfg_parity_en   = 1'(pen);
        cfg_parity_type = 2'(pt);
        cfg_stop2       = 1'(s2);
        cur_bits   = nbits;
        cur_par_en = pen;
        cur_ptype  = pt;
        cur_stop2  = s2;
    endtask

    function automatic int frame_len();
        return (1 + cur_bits + cur_par_en + 1 + cur_stop2) * 16;
    endfunction

    // Bit idx of the frame for byte b: start, data LSB first, parity, stop(s).
    function automatic logic exp_bit(input logic [7:0] b, input int idx);
        int ones = 0;
        if (idx == 0) return 1'b0;
        if (idx <= cur_bits) return b[idx-1];
        if (cur_par_en != 0 && idx == cur_bits + 1) begin
            for (int i = 0; i < cur_bits; i++) ones += int'(b[i]);
            case (cur_ptype)
                0: return 1'(ones % 2);
                1: return 1'((ones + 1) % 2);
                2: return 1'b1;
                default: return 1'b0;
            endcase
        end
        return 1'b1;
    endfunction

    task automatic wr_byte(input logic [7:0] d, output logic ovf);
        wr_data = d;
        wr_en   = 1'b1;
        @(negedge uart_clk);
        ovf   = wr_overflow;
        wr_en = 1'b0;
    endtask

    // Captures nfr contiguous frames starting at the first low sample and checks them.
    task automatic run_frames(input int nfr, input bit started, input int brk_at, input bit scramble);
        int         flen;
        int         total;
        int         bad;
        int         ndone;
        logic [7:0] fb [0:15];
        logic       eb;
        flen  = frame_len();
        total = nfr * flen;
        if (!started) begin
            int w = 0;
            while (tx_serial !== 1'b0 && w < 200) begin
                @(negedge uart_clk);
                w++;
            end
            if (tx_serial !== 1'b0) begin
                chk("start_timeout", 32'(tx_serial), 32'd0);
                return;
            end
        end
        for (int i = 0; i <= total; i++) begin
            if (i > 0) @(negedge uart_clk);
            line_s[i] = tx_serial;
            done_s[i] = tx_done;
            if (i % flen == 0 && i < total) begin
                model_level--;
                fb[i/flen] = (exp_q.size() > 0) ? exp_q.pop_front() : 8'h00;
                chk("level_at_start", 32'(tx_level), 32'(model_level));
                chk("active_in_frame", 32'(tx_active), 32'd1);
            end
            if (i == brk_at) cfg_break = 1'b1;
            if (scramble && i == flen / 2) begin
                cfg_data_bits   = 2'($urandom);
                cfg_parity_en   = 1'($urandom);
                cfg_parity_type = 2'($urandom);
                cfg_stop2       = 1'($urandom);
            end
        end
        for (int k = 0; k < nfr; k++) begin
            for (int b = 0; b < flen / 16; b++) begin
                eb  = exp_bit(fb[k], b);
                bad = 0;
                for (int s = 0; s < 16; s++)
                    if (line_s[k*flen + b*16 + s] !== eb) bad++;
                chk($sformatf("frame%0d_bit%0d_exp%0d_bad_samples", k, b, eb), 32'(bad), 32'd0);
            end
            chk($sformatf("frame%0d_done_at_end", k), 32'(done_s[(k+1)*flen]), 32'd1);
        end
        ndone = 0;
        for (int i = 0; i <= total; i++) if (done_s[i] === 1'b1) ndone++;
        chk("done_count", 32'(ndone), 32'(nfr));
    endtask

    task automatic one_frame(input logic [7:0] b, input bit scr);
        logic ovf;
        exp_q.push_back(b);
        model_level++;
        wr_byte(b, ovf);
        chk("no_overflow", 32'(ovf), 32'd0);
        run_frames(1, 1'b0, -1, scr);
        repeat (3) @(negedge uart_clk);
    endtask

    initial begin
        logic ovf;
        int   bad;
        int   hi;
        int   ndone;

        rst_n = 1'b0;
        baud_tick = 1'b1;
        cfg_break = 1'b0;
        cfg_cts_en = 1'b0;
        cts_n = 1'b1;
        wr_data = 8'h00;
        wr_en = 1'b0;
        flush = 1'b0;
        set_cfg(8, 0, 0, 0);

        repeat (3) @(negedge uart_clk);
        chk("rst_serial", 32'(tx_serial), 32'd1);
        chk("rst_empty", 32'(tx_empty), 32'd1);
        chk("rst_full", 32'(tx_full), 32'd0);
        chk("rst_level", 32'(tx_level), 32'd0);
        chk("rst_active", 32'(tx_active), 32'd0);
        chk("rst_done", 32'(tx_done), 32'd0);
        chk("rst_overflow", 32'(wr_overflow), 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge uart_clk);

        // Directed formats
        set_cfg(8, 0, 0, 0);
        one_frame(8'hA5, 1'b0);
        set_cfg(7, 1, 0, 1);
        one_frame(8'h41, 1'b0);
        set_cfg(5, 1, 1, 0);
        one_frame(8'hFF, 1'b0);

        // Random formats, config scrambled mid-frame
        for (int n = 0; n < 6; n++) begin
            set_cfg(int'($urandom_range(8, 5)), int'($urandom_range(1, 0)),
                    int'($urandom_range(3, 0)), int'($urandom_range(1, 0)));
            one_frame(8'($urandom), 1'b1);
        end

        // CTS hold-off, flush, fill to full, overflow, then contiguous burst
        set_cfg(int'($urandom_range(8, 5)), int'($urandom_range(1, 0)),
                int'($urandom_range(3, 0)), int'($urandom_range(1, 0)));
        cfg_cts_en = 1'b1;
        cts_n = 1'b1;
        repeat (3) @(negedge uart_clk);
        bad = 0;
        for (int n = 0; n < 3; n++) begin
            wr_byte(8'($urandom), ovf);
            model_level++;
            if (tx_serial !== 1'b1) bad++;
        end
        chk("level_before_flush", 32'(tx_level), 32'(model_level));
        flush = 1'b1;
        @(negedge uart_clk);
        flush = 1'b0;
        model_level = 0;
        chk("level_after_flush", 32'(tx_level), 32'd0);
        chk("empty_after_flush", 32'(tx_empty), 32'd1);
        for (int n = 0; n < 17; n++) begin
            logic [7:0] d;
            d = 8'($urandom);
            wr_byte(d, ovf);
            if (n < 16) begin
                exp_q.push_back(d);
                model_level++;
            end
            if (n == 15) chk("no_overflow_16th", 32'(ovf), 32'd0);
            if (n == 16) chk("overflow_17th", 32'(ovf), 32'd1);
            if (tx_serial !== 1'b1) bad++;
        end
        repeat (20) begin
            @(negedge uart_clk);
            if (tx_serial !== 1'b1) bad++;
        end
        chk("line_high_while_cts_blocked", 32'(bad), 32'd0);
        chk("level_full", 32'(tx_level), 32'd16);
        chk("full_flag", 32'(tx_full), 32'd1);
        cts_n = 1'b0;
        run_frames(16, 1'b0, -1, 1'b0);
        chk("empty_after_burst", 32'(tx_empty), 32'd1);
        cfg_cts_en = 1'b0;
        cts_n = 1'b1;
        repeat (5) @(negedge uart_clk);

        // Break raised during data; pending byte waits for break and mark
        set_cfg(8, 0, 0, 0);
        exp_q.push_back(8'h3C);
        model_level++;
        wr_byte(8'h3C, ovf);
        run_frames(1, 1'b0, 40, 1'b0);
        exp_q.push_back(8'hC6);
        model_level++;
        wr_byte(8'hC6, ovf);
        bad = 0;
        for (int n = 0; n < 40; n++) begin
            if (tx_serial !== 1'b0) bad++;
            @(negedge uart_clk);
        end
        chk("break_line_low", 32'(bad), 32'd0);
        chk("break_level_pending", 32'(tx_level), 32'(model_level));
        chk("break_active", 32'(tx_active), 32'd1);
        cfg_break = 1'b0;
        hi = 0;
        @(negedge uart_clk);
        while (tx_serial === 1'b1 && hi < 100) begin
            hi++;
            @(negedge uart_clk);
        end
        chk("mark_high_at_least_16", 32'(hi >= 16), 32'd1);
        chk("mark_high_bounded", 32'(hi <= 20), 32'd1);
        if (tx_serial === 1'b0) run_frames(1, 1'b1, -1, 1'b0);
        else chk("post_break_start", 32'(tx_serial), 32'd0);
        repeat (3) @(negedge uart_clk);

        // Reset in the middle of a data bit
        set_cfg(8, 0, 0, 0);
        for (int n = 0; n < 3; n++) wr_byte(8'($urandom), ovf);
        repeat (50) @(negedge uart_clk);
        chk("level_before_reset", 32'(tx_level), 32'd2);
        chk("active_before_reset", 32'(tx_active), 32'd1);
        rst_n = 1'b0;
        @(negedge uart_clk);
        rst_n = 1'b1;
        chk("reset_mid_serial", 32'(tx_serial), 32'd1);
        chk("reset_mid_level", 32'(tx_level), 32'd0);
        chk("reset_mid_active", 32'(tx_active), 32'd0);
        chk("reset_mid_done", 32'(tx_done), 32'd0);
        bad = 0;
        ndone = 0;
        repeat (300) begin
            @(negedge uart_clk);
            if (tx_serial !== 1'b1) bad++;
            if (tx_done === 1'b1) ndone++;
        end
        chk("after_reset_line_idle", 32'(bad), 32'd0);
        chk("after_reset_no_done", 32'(ndone), 32'd0);
        exp_q.delete();
        model_level = 0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
